// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack data-memory
// handshake, aligns store lanes, extends load data and registers results toward WB.
module mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] pc4,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        branch_result,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_branch,
  output logic        misaligned,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc4,
  output logic [4:0]  wb_rd
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state, state_next;
  logic        accept, start, finish;
  logic        is_mem, is_load, is_store, mis;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] lane, ld_data;

  // Operands captured at acceptance for use when the ack returns
  logic [1:0]  off_q, size_q;
  logic        uns_q, load_q, reg_write_q, branch_q;
  logic [31:0] addr_q, pc4_q;
  logic [4:0]  rd_q;

  assign stall = (state == ACCESS);

  // Instruction decode and store lane placement
  always_comb begin
    is_mem   = mem_read | mem_write;
    is_load  = mem_read;
    is_store = mem_write & ~mem_read;
    mis      = is_mem & (((mem_size == 2'b01) & address[0]) |
                         (mem_size[1] & (address[1:0] != 2'b00)));
    st_wstrb = 4'b1111;
    st_wdata = wr_data;
    case (mem_size)
      2'b00: begin
        st_wstrb = 4'b0001 << address[1:0];
        st_wdata = {4{wr_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = address[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wr_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = wr_data;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    lane    = dmem_rdata >> {off_q, 3'b000};
    ld_data = lane;
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_data = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (is_mem && !mis) begin
            start      = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory request, captured operands and WB registers
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'b0;
      dmem_wstrb   <= 4'b0;
      dmem_wdata   <= 32'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_branch    <= 1'b0;
      misaligned   <= 1'b0;
      wb_data      <= 32'b0;
      wb_pc4       <= 32'b0;
      wb_rd        <= 5'b0;
      off_q        <= 2'b0;
      size_q       <= 2'b0;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      addr_q       <= 32'b0;
      pc4_q        <= 32'b0;
      rd_q         <= 5'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      if (start) begin
        dmem_req    <= 1'b1;
        dmem_we     <= is_store;
        dmem_addr   <= {address[31:2], 2'b00};
        dmem_wstrb  <= is_store ? st_wstrb : 4'b0000;
        dmem_wdata  <= is_store ? st_wdata : 32'b0;
        off_q       <= address[1:0];
        size_q      <= mem_size;
        uns_q       <= mem_unsigned;
        load_q      <= is_load;
        reg_write_q <= reg_write;
        branch_q    <= branch_result;
        addr_q      <= address;
        pc4_q       <= pc4;
        rd_q        <= rd;
      end else if (accept) begin
        wb_valid     <= 1'b1;
        wb_data      <= address;
        wb_pc4       <= pc4;
        wb_rd        <= rd;
        wb_branch    <= branch_result;
        wb_reg_write <= reg_write & ~mis;
        misaligned   <= mis;
      end
      if (finish) begin
        dmem_req     <= 1'b0;
        dmem_we      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_data      <= load_q ? ld_data : addr_q;
        wb_reg_write <= load_q & reg_write_q;
        wb_pc4       <= pc4_q;
        wb_rd        <= rd_q;
        wb_branch    <= branch_q;
      end
    end
  end

endmodule
